// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-master memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 8;
  localparam int MAX_HOLD_DEF = 4;
  localparam int HOLD_W       = 4;

  function automatic owner_t other_owner(input owner_t o);
    return (o == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin winner selection with a bounded-hold limit.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic [1:0]        req_i,
  input  owner_t            last_i,
  input  logic [HOLD_W-1:0] hold_cnt_i,
  input  logic              prev_granted_i,
  output logic [1:0]        gnt_o,
  output owner_t            winner_o
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_L = HOLD_W'(MAX_HOLD);

  always_comb begin
    gnt_o    = 2'b00;
    winner_o = M0;
    unique case (req_i)
      2'b01: begin
        winner_o = M0;
        gnt_o    = 2'b01;
      end
      2'b10: begin
        winner_o = M1;
        gnt_o    = 2'b10;
      end
      2'b11: begin
        // Burst continues only while under the hold limit; idle restarts rotation.
        if (hold_cnt_i == MAX_HOLD_L)
          winner_o = other_owner(last_i);
        else if (prev_granted_i)
          winner_o = last_i;
        else
          winner_o = other_owner(last_i);
        gnt_o = (winner_o == M1) ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single 8-bit memory port: grant registers,
// memory-side mux and the one-cycle read-valid pipeline.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_L = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  owner_t            last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        rd_pend_q, rd_pend_d;

  logic [1:0] req;
  logic [1:0] gnt;
  owner_t     winner;
  logic       prev_granted;

  // Masking requests during reset keeps grants and mem_we low without extra gating.
  assign req          = {m1_req, m0_req} & {2{~reset}};
  assign prev_granted = (hold_q != '0);

  rr_pick #(
    .MAX_HOLD(MAX_HOLD)
  ) u_rr_pick (
    .req_i         (req),
    .last_i        (last_q),
    .hold_cnt_i    (hold_q),
    .prev_granted_i(prev_granted),
    .gnt_o         (gnt),
    .winner_o      (winner)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  assign mem_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign mem_wdata = gnt[1] ? m1_wdata : m0_wdata;
  assign mem_we    = (gnt[0] & m0_we) | (gnt[1] & m1_we);

  assign m0_rvalid = rd_pend_q[0] & ~reset;
  assign m1_rvalid = rd_pend_q[1] & ~reset;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  always_comb begin
    last_d    = last_q;
    hold_d    = '0;
    rd_pend_d = gnt & ~{m1_we, m0_we};
    if (gnt != 2'b00) begin
      last_d = winner;
      if ((winner == last_q) && prev_granted)
        hold_d = (hold_q >= MAX_HOLD_L) ? MAX_HOLD_L : hold_q + HOLD_ONE;
      else
        hold_d = HOLD_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= M1;
      hold_q    <= '0;
      rd_pend_q <= 2'b00;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: one arbiter with MAX_HOLD=4 and one with MAX_HOLD=1, each on its own memory model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  logic       b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [7:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic       b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [7:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic       b_mem_we;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_HOLD(1)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  // Synchronous memories: write commits at the edge, read data appears the next cycle.
  always @(posedge clk) begin
    if (mem_we) mem_a[mem_addr] <= mem_wdata;
    mem_rdata <= mem_a[mem_addr];
    if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= mem_b[b_mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(1'b1, 1'b1, 8'h05, 8'hAA, 1'b1, 1'b0, 8'h06, 8'h00);
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b want 00", {m1_gnt, m0_gnt});
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem_we got %b want 0", mem_we);
    end
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got %b want 00", {m1_rvalid, m0_rvalid});
    end
  endtask

  task automatic test_m0_read();
    tick();
    reset = 1'b0;
    drv(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL m0_read_gnt got %b want 01", {m1_gnt, m0_gnt});
    end
    checks++;
    if (mem_addr !== 8'h10 || mem_we !== 1'b0) begin
      errors++; $display("FAIL m0_read_mem got addr %h we %b want addr 10 we 0", mem_addr, mem_we);
    end
    tick();
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h5A) begin
      errors++; $display("FAIL m0_read_data got v %b d %h want v 1 d 5a", m0_rvalid, m0_rdata);
    end
    checks++;
    if (m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL m0_read_m1v got %b want 0", m1_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL m0_read_once got %b want 0", m0_rvalid);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] pat [9];
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== pat[i]) begin
        errors++; $display("FAIL simul_gnt cycle %0d got %b want %b", i, {m1_gnt, m0_gnt}, pat[i]);
      end
      tick();
    end
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_forfeit();
    logic [1:0] pat [7];
    logic [6:0] r0v, r1v;
    pat = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    r0v = 7'b1111110;
    r1v = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      drv(r0v[i], 1'b0, 8'h03, 8'h00, r1v[i], 1'b0, 8'h04, 8'h00);
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== pat[i]) begin
        errors++; $display("FAIL forfeit_gnt cycle %0d got %b want %b", i, {m1_gnt, m0_gnt}, pat[i]);
      end
      tick();
    end
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid_read();
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      errors++; $display("FAIL rstmid_gnt got %b want 10", {m1_gnt, m0_gnt});
    end
    tick();
    reset = 1'b1;
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_rvalid_in_reset got %b want 0", m1_rvalid);
    end
    tick();
    reset = 1'b0;
    drv(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, 8'h08, 8'h00);
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_rvalid_after got %b want 0", m1_rvalid);
    end
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL rstmid_priority got %b want 01", {m1_gnt, m0_gnt});
    end
    tick();
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_mixed_burst();
    logic [3:0] v_exp;
    logic [7:0] d_exp [4];
    v_exp = 4'b1010;
    d_exp = '{8'h00, 8'h5A, 8'h00, 8'h33};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drv(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        1: drv(1'b1, 1'b1, 8'h20, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00);
        2: drv(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        default: drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      endcase
      @(negedge clk);
      checks++;
      if (m0_rvalid !== v_exp[i]) begin
        errors++; $display("FAIL mixed_rvalid cycle %0d got %b want %b", i, m0_rvalid, v_exp[i]);
      end
      if (v_exp[i]) begin
        checks++;
        if (m0_rdata !== d_exp[i]) begin
          errors++; $display("FAIL mixed_rdata cycle %0d got %h want %h", i, m0_rdata, d_exp[i]);
        end
      end
      if (i == 1) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h33) begin
          errors++; $display("FAIL mixed_write got we %b a %h d %h want 1 20 33", mem_we, mem_addr, mem_wdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_max_hold_one();
    b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 8'h40; b_m0_wdata = 8'h11;
    b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 8'h41; b_m1_wdata = 8'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({b_m1_gnt, b_m0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_gnt cycle %0d got %b want %b", i, {b_m1_gnt, b_m0_gnt},
                           ((i % 2 == 0) ? 2'b01 : 2'b10));
      end
      tick();
    end
    b_m0_we = 1'b0; b_m1_req = 1'b0; b_m1_we = 1'b0;
    tick();
    b_m0_req = 1'b0; b_m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if (b_m0_rvalid !== 1'b1 || b_m0_rdata !== 8'h11) begin
      errors++; $display("FAIL alt_rd0 got v %b d %h want v 1 d 11", b_m0_rvalid, b_m0_rdata);
    end
    tick();
    b_m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b_m1_rvalid !== 1'b1 || b_m1_rdata !== 8'h22) begin
      errors++; $display("FAIL alt_rd1 got v %b d %h want v 1 d 22", b_m1_rvalid, b_m1_rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[8'h10] = 8'h5A;
    mem_rdata = 8'h00;
    b_mem_rdata = 8'h00;
    reset = 1'b1;
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 8'h00; b_m0_wdata = 8'h00;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 8'h00; b_m1_wdata = 8'h00;

    test_reset();
    test_m0_read();
    test_simultaneous();
    test_forfeit();
    test_reset_mid_read();
    test_mixed_burst();
    test_max_hold_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the single 8-bit memory port (Address / WriteData / writeEnable / Data). It shares the memory between the CPU (master 0) and a second requester such as a UART loader or DMA engine (master 1). Arbitration is round-robin with a bounded-hold rule, so neither master can starve the other. Grants take effect the same cycle, and read data is returned with a fixed one-cycle latency.

## Interface
- AW, 8, address width
- DW, 8, data width
- MAX_HOLD, 4, maximum consecutive granted beats for one master while the other is requesting; legal range 1..15
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- m0_req / m1_req  input  1  access request; held with stable attributes until granted
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_addr / m1_addr  input  AW  access address
- m0_wdata / m1_wdata  input  DW  write data
- m0_gnt / m1_gnt  output  1  access accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  output  1  read data valid this cycle (registered)
- m0_rdata / m1_rdata  output  DW  read data, both driven from mem_rdata
- mem_addr  output  AW  to memory Address
- mem_wdata  output  DW  to memory WriteData
- mem_we  output  1  to memory writeEnable
- mem_rdata  input  DW  from memory Data; valid the cycle after the address is presented

## Operation
- Each granted cycle is exactly one beat: one read or one write.
- Registered state:
  - last, the owner of the previous granted beat; reset value 1, so m0 has first priority
  - hold_cnt, 4 bits, reset value 0
  - rd_pend, 2 bits, one per master
- Winner selection each cycle:
  - Only one master requesting: that master wins.
  - Both requesting, hold_cnt < MAX_HOLD: last wins (burst continues). If no burst is in progress (previous cycle idle), the master not equal to last wins.
  - Both requesting, hold_cnt == MAX_HOLD: the other master wins (forced rotation).
- hold_cnt update:
  - Winner == last and previous cycle granted: increment, saturating at MAX_HOLD.
  - Otherwise: set to 1.
  - No grant this cycle: set to 0.
- The winner's addr, wdata and we drive the mem_* outputs.
- With no winner: mem_we = 0, and mem_addr / mem_wdata hold the m0 values (don't-care, but deterministic).
- rd_pend[i] <= gnt_i & ~we_i. The outputs mi_rvalid come from rd_pend[i].
- MAX_HOLD = 1 gives strict alternation under contention.

## Timing
- Grant latency 0: gnt is asserted in the same cycle as req when the master wins.
- Write commits at the rising edge that ends the grant cycle.
- Read latency 1: rvalid is high the cycle after gnt, for exactly one cycle per granted read.
- Back-to-back reads by the same master give rvalid on consecutive cycles.
- A write granted in the cycle after a read does not disturb that read's rvalid or rdata.
- While reset is high:
  - gnt = 0 and mem_we = 0, regardless of req
  - rvalid = 0
- Reset taken mid-burst or with a read pending:
  - rd_pend is cleared, so no rvalid appears after reset
  - hold_cnt goes to 0 and last goes to 1
- A master that drops req after hold_cnt reaches MAX_HOLD forfeits the rotation. The counter restarts when it next wins.

## Structure
- Package mem_arb_pkg holds:
  - typedef owner_t (1 bit, enum M0/M1)
  - constants AW_DEF, DW_DEF, MAX_HOLD_DEF
  - width of hold_cnt (HOLD_W = 4)
- One sub-module, rr_pick: purely combinational winner selection from (req[1:0], last, hold_cnt, prev_granted, MAX_HOLD). Kept separate so the arbitration policy can be tested exhaustively on its own.
- The top module holds the registers, the mem_* mux and the rvalid pipeline.

## Test plan
- **Reset release, m0 only:** reset released, m0 reads addr 0x10 where memory holds 0x5A → m0_gnt same cycle, m0_rvalid=1 with m0_rdata=0x5A one cycle later, m1_rvalid stays 0.
- **Simultaneous first request:** both request from idle right after reset → m0 granted first; with MAX_HOLD=4 and both held high, the grant pattern is 0,0,0,0,1,1,1,1,0…
- **MAX_HOLD=1:** both continuously request writes of 0x11 (m0) and 0x22 (m1) to distinct addresses → grants strictly alternate, and each address reads back its own value.
- **Rotation forfeited:** m1 requests, then drops req after 2 beats while m0 waits → m0 granted in the cycle m1 drops; hold_cnt restarts at 1.
- **Reset mid-read:** reset asserted the cycle after an m1 read grant → m1_rvalid never asserts; after release, m0 has priority.
- **Mixed burst:** m0 issues read, write 0x33 to 0x20, read 0x20 back-to-back → rvalid pulses on the 2nd and 4th cycles only, and the second read returns 0x33.
